// File: rtl/tetris_op_scheduler.sv
// tetris_op_scheduler: arbitrates user requests and gravity into single-outstanding opcodes for the tile engine.
// Optional macro TETRIS_HARD_DROP_EN enables hard drop (repeated eMoveDown until blocked).
package tetris;
  typedef enum logic [2:0] {
    eNop = 3'd0, eNew = 3'd1, eMoveLeft = 3'd2, eMoveRight = 3'd3,
    eMoveDown = 3'd4, eRotate = 3'd5, eCommit = 3'd6, eCheck = 3'd7
  } opcode_e;
  typedef enum logic [2:0] {
    eNon = 3'd0, eI = 3'd1, eJ = 3'd2, eL = 3'd3, eO = 3'd4, eS = 3'd5, eT = 3'd6, eZ = 3'd7
  } tile_type_e;
endpackage

module tetris_op_scheduler
  import tetris::*;
#(
  parameter int unsigned gravity_period_p = 1000000
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       rotate_i,
  input  logic       drop_i,
  output logic       op_v_o,
  output opcode_e    op_o,
  input  logic       op_ready_i,
  input  logic       done_v_i,
  input  logic       done_ok_i,
  output tile_type_e new_tile_o,
  output logic       game_over_o
);

  localparam int unsigned CntW = $clog2(gravity_period_p);

  typedef enum logic [2:0] {
    S_IDLE, S_NEW, S_PLAY, S_ISSUE, S_WAIT, S_COMMIT, S_CHECK, S_OVER
  } state_e;

  state_e          r_state;
  opcode_e         r_op;
  tile_type_e      r_tile;
  logic            r_op_v;
  logic            r_game_over;
  logic            r_grav;
  logic            r_left;
  logic            r_right;
  logic            r_rot;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_lfsr;
`ifdef TETRIS_HARD_DROP_EN
  logic            r_drop;
  logic            r_hd;
`else
  logic            w_unused_drop;
  assign w_unused_drop = drop_i;
`endif

  logic       w_drop_req;
  logic       w_hd;
  logic       w_cnt_en;
  logic       w_wrap;
  logic       w_any;
  opcode_e    w_play_op;
  tile_type_e w_tile;

  always_comb begin
`ifdef TETRIS_HARD_DROP_EN
    w_drop_req = r_drop;
    w_hd       = r_hd;
`else
    w_drop_req = 1'b0;
    w_hd       = 1'b0;
`endif
    w_cnt_en  = (r_state == S_PLAY) || (r_state == S_ISSUE) || (r_state == S_WAIT);
    w_wrap    = w_cnt_en && (r_cnt == CntW'(gravity_period_p - 1));
    w_any     = r_grav | w_drop_req | r_rot | r_left | r_right;
    if (r_grav || w_drop_req) w_play_op = eMoveDown;
    else if (r_rot)           w_play_op = eRotate;
    else if (r_left)          w_play_op = eMoveLeft;
    else                      w_play_op = eMoveRight;
    w_tile = (r_lfsr[2:0] == 3'd0) ? eI : tile_type_e'(r_lfsr[2:0]);
  end

  // Request sets are written before the state case, so a load clears a bit with "<= new pulse"
  // (set wins) while COMMIT entry and eNew success use hard clears (clear wins).
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_op        <= eNop;
      r_tile      <= eI;
      r_op_v      <= 1'b0;
      r_game_over <= 1'b0;
      r_grav      <= 1'b0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_rot       <= 1'b0;
      r_cnt       <= '0;
      r_lfsr      <= 4'b1001;
`ifdef TETRIS_HARD_DROP_EN
      r_drop      <= 1'b0;
      r_hd        <= 1'b0;
`endif
    end else begin
      r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      if (w_cnt_en) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_grav <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end
      if (left_i)   r_left  <= 1'b1;
      if (right_i)  r_right <= 1'b1;
      if (rotate_i) r_rot   <= 1'b1;
`ifdef TETRIS_HARD_DROP_EN
      if (drop_i)   r_drop  <= 1'b1;
`endif
      case (r_state)
        S_IDLE: if (start_i) r_state <= S_NEW;
        S_NEW: begin
          r_op    <= eNew;
          r_tile  <= w_tile;
          r_op_v  <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_PLAY: if (w_any) begin
          r_op    <= w_play_op;
          r_op_v  <= 1'b1;
          r_state <= S_ISSUE;
          if (r_grav) begin
            r_grav <= w_wrap;
          end else if (w_drop_req) begin
`ifdef TETRIS_HARD_DROP_EN
            r_drop <= drop_i;
            r_hd   <= 1'b1;
`endif
          end else if (r_rot) begin
            r_rot <= rotate_i;
          end else if (r_left) begin
            r_left <= left_i;
          end else begin
            r_right <= right_i;
          end
        end
        S_ISSUE: if (op_ready_i) begin
          r_op_v  <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (done_v_i) begin
          case (r_op)
            eNew: if (done_ok_i) begin
              r_state <= S_PLAY;
              r_cnt   <= '0;
              r_grav  <= 1'b0;
            end else begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end
            eMoveDown: if (done_ok_i) begin
              if (w_hd) begin
                r_op_v  <= 1'b1;
                r_grav  <= w_wrap;
                r_state <= S_ISSUE;
              end else begin
                r_state <= S_PLAY;
              end
            end else begin
              r_state <= S_COMMIT;
              r_left  <= 1'b0;
              r_right <= 1'b0;
              r_rot   <= 1'b0;
`ifdef TETRIS_HARD_DROP_EN
              r_drop  <= 1'b0;
              r_hd    <= 1'b0;
`endif
            end
            eCommit: r_state <= S_CHECK;
            eCheck:  r_state <= S_NEW;
            default: r_state <= S_PLAY;
          endcase
        end
        S_COMMIT: begin
          r_op    <= eCommit;
          r_op_v  <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_CHECK: begin
          r_op    <= eCheck;
          r_op_v  <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_OVER: if (start_i) begin
          r_state     <= S_IDLE;
          r_game_over <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_v_o      = r_op_v;
  assign op_o        = r_op;
  assign new_tile_o  = r_tile;
  assign game_over_o = r_game_over;

endmodule

// File: tb/tb_tetris_op_scheduler.sv
// Randomized bench for tetris_op_scheduler: plays the tile engine and predicts every opcode
// and its issue cycle from per-request queues of pulse times plus a gravity timetable.
`timescale 1ns/1ps
module tb_tetris_op_scheduler;
  import tetris::*;

  localparam int Period = 8;
  localparam int NOps   = 300;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic       left_i = 1'b0;
  logic       right_i = 1'b0;
  logic       rotate_i = 1'b0;
  logic       drop_i = 1'b0;
  logic       op_ready_i = 1'b0;
  logic       done_v_i = 1'b0;
  logic       done_ok_i = 1'b0;
  logic       op_v_o;
  logic       game_over_o;
  opcode_e    op_o;
  tile_type_e new_tile_o;

  tetris_op_scheduler #(.gravity_period_p(Period)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .left_i(left_i), .right_i(right_i), .rotate_i(rotate_i), .drop_i(drop_i),
    .op_v_o(op_v_o), .op_o(op_o), .op_ready_i(op_ready_i),
    .done_v_i(done_v_i), .done_ok_i(done_ok_i),
    .new_tile_o(new_tile_o), .game_over_o(game_over_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge numbering: after the n-th rising edge, cyc == n.
  int cyc = 0;
  int rst_edge = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (!reset_n_i) rst_edge <= cyc + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference model: edges at which each request was captured, not yet consumed.
  int q_rot[$], q_left[$], q_right[$], q_drop[$];
  int e0 = 0, g_clear = 0, last_done = 0, next_l = 0;
  bit hd = 1'b0;
  typedef enum {PH_NEW, PH_PIECE, PH_COMMIT, PH_CHECK} phase_e;
  phase_e ph = PH_NEW;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  task automatic tick(input bit pulses);
    if (pulses) begin
      left_i   = ($urandom_range(5) == 0);
      right_i  = ($urandom_range(5) == 0);
      rotate_i = ($urandom_range(5) == 0);
      drop_i   = ($urandom_range(7) == 0);
      if (left_i)   q_left.push_back(cyc + 1);
      if (right_i)  q_right.push_back(cyc + 1);
      if (rotate_i) q_rot.push_back(cyc + 1);
`ifdef TETRIS_HARD_DROP_EN
      if (drop_i)   q_drop.push_back(cyc + 1);
`endif
    end
    @(posedge clk_i);
    #1;
    left_i = 1'b0; right_i = 1'b0; rotate_i = 1'b0; drop_i = 1'b0;
    start_i = 1'b0; done_v_i = 1'b0; done_ok_i = 1'b0;
  endtask

  function automatic int tile_at(input int steps);
    int x = 9;
    for (int i = 0; i < steps; i++) x = ((x << 1) | (((x >> 3) ^ (x >> 2)) & 1)) & 15;
    return ((x & 7) == 0) ? 1 : (x & 7);
  endfunction

  function automatic int next_grav();
    int m = (g_clear - e0 + Period - 1) / Period;
    if (m < 1) m = 1;
    return e0 + m * Period;
  endfunction

  task automatic clear_upto(input int e);
    while (q_rot.size() > 0 && q_rot[0] <= e)     void'(q_rot.pop_front());
    while (q_left.size() > 0 && q_left[0] <= e)   void'(q_left.pop_front());
    while (q_right.size() > 0 && q_right[0] <= e) void'(q_right.pop_front());
    while (q_drop.size() > 0 && q_drop[0] <= e)   void'(q_drop.pop_front());
  endtask

  // Earliest cycle something is pending decides the issue cycle; priority decides the op.
  task automatic arbitrate(output opcode_e op, output int l, output int pick);
    int g = next_grav();
    int first = g;
    if (q_drop.size() > 0 && q_drop[0] < first)   first = q_drop[0];
    if (q_rot.size() > 0 && q_rot[0] < first)     first = q_rot[0];
    if (q_left.size() > 0 && q_left[0] < first)   first = q_left[0];
    if (q_right.size() > 0 && q_right[0] < first) first = q_right[0];
    l = (last_done + 1 > first + 1) ? last_done + 1 : first + 1;
    if (g <= l - 1)                                     begin op = eMoveDown;  pick = 0; end
    else if (q_drop.size() > 0 && q_drop[0] <= l - 1)   begin op = eMoveDown;  pick = 1; end
    else if (q_rot.size() > 0 && q_rot[0] <= l - 1)     begin op = eRotate;    pick = 2; end
    else if (q_left.size() > 0 && q_left[0] <= l - 1)   begin op = eMoveLeft;  pick = 3; end
    else                                                begin op = eMoveRight; pick = 4; end
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 64; i++) begin
      if (op_v_o) break;
      tick(1'b0);
    end
    check_eq("issue_seen", op_v_o, 1);
    if (!op_v_o) begin
      summary();
      $finish;
    end
  endtask

  // Stall, accept, optional latency, then completion; stray done pulses during stall must be ignored.
  task automatic serve(input bit ok, input int stall, input int wlat);
    opcode_e held = op_o;
    for (int i = 0; i < stall; i++) begin
      op_ready_i = 1'b0;
      done_v_i   = ($urandom_range(1) == 1);
      done_ok_i  = ($urandom_range(1) == 1);
      tick(1'b1);
      check_eq("hold_valid", op_v_o, 1);
      check_eq("hold_opcode", op_o, held);
    end
    op_ready_i = 1'b1;
    tick(1'b0);
    op_ready_i = 1'b0;
    check_eq("valid_drops_in_wait", op_v_o, 0);
    for (int i = 0; i < wlat; i++) tick(1'b1);
    done_v_i  = 1'b1;
    done_ok_i = ok;
    tick(1'b0);
  endtask

  task automatic over_seq();
    check_eq("game_over_set", game_over_o, 1);
    tick(1'b1);
    check_eq("over_no_op", op_v_o, 0);
    start_i = 1'b1;
    tick(1'b0);
    check_eq("game_over_clear", game_over_o, 0);
    tick(1'b1);
    tick(1'b1);
    check_eq("idle_no_op", op_v_o, 0);
    start_i = 1'b1;
    tick(1'b0);
    next_l = cyc + 1;
    ph = PH_NEW;
  endtask

  initial begin
    opcode_e exp_op;
    int exp_l, d, pick;
    bit ok;
    exp_op = eNop; exp_l = 0; pick = -1; ok = 1'b0;

    repeat (3) tick(1'b0);
    check_eq("rst_op_v", op_v_o, 0);
    check_eq("rst_op", op_o, eNop);
    check_eq("rst_game_over", game_over_o, 0);
    check_eq("rst_tile", new_tile_o, eI);
    reset_n_i = 1'b1;
    tick(1'b0);
    check_eq("idle_no_op_after_rst", op_v_o, 0);
    start_i = 1'b1;
    tick(1'b0);
    next_l = cyc + 1;
    ph = PH_NEW;

    for (int n = 0; n < NOps; n++) begin
      pick = -1;
      case (ph)
        PH_NEW:    begin exp_op = eNew;    exp_l = next_l; end
        PH_COMMIT: begin exp_op = eCommit; exp_l = next_l; end
        PH_CHECK:  begin exp_op = eCheck;  exp_l = next_l; end
        default: begin
          if (hd) begin exp_op = eMoveDown; exp_l = next_l; end
          else arbitrate(exp_op, exp_l, pick);
        end
      endcase
      wait_issue();
      check_eq("opcode", op_o, exp_op);
      check_eq("issue_cycle", cyc, exp_l);
      if (exp_op == eNew) check_eq("new_tile", new_tile_o, tile_at(exp_l - 1 - rst_edge));
      if (exp_op == eMoveDown) g_clear = exp_l;
      case (pick)
        1: begin hd = 1'b1; while (q_drop.size() > 0 && q_drop[0] <= exp_l - 1) void'(q_drop.pop_front()); end
        2: while (q_rot.size() > 0 && q_rot[0] <= exp_l - 1)     void'(q_rot.pop_front());
        3: while (q_left.size() > 0 && q_left[0] <= exp_l - 1)   void'(q_left.pop_front());
        4: while (q_right.size() > 0 && q_right[0] <= exp_l - 1) void'(q_right.pop_front());
        default: ;
      endcase
      if (exp_op == eNew || exp_op == eMoveDown) ok = ($urandom_range(3) != 0);
      else ok = ($urandom_range(1) == 1);
      serve(ok, $urandom_range(5), $urandom_range(3));
      d = cyc;
      case (exp_op)
        eNew: begin
          if (ok) begin ph = PH_PIECE; e0 = d; g_clear = d; last_done = d; hd = 1'b0; end
          else over_seq();
        end
        eMoveDown: begin
          if (ok) begin
            if (hd) next_l = d;
            else last_done = d;
          end else begin
            hd = 1'b0;
            clear_upto(d);
            ph = PH_COMMIT;
            next_l = d + 1;
          end
        end
        eCommit: begin ph = PH_CHECK; next_l = d + 1; end
        eCheck:  begin ph = PH_NEW;   next_l = d + 1; end
        default: last_done = d;
      endcase
    end

    // Reset while an op is outstanding: the late completion must not restart anything.
    wait_issue();
    op_ready_i = 1'b1;
    tick(1'b0);
    op_ready_i = 1'b0;
    reset_n_i = 1'b0;
    tick(1'b0);
    reset_n_i = 1'b1;
    check_eq("midop_rst_op_v", op_v_o, 0);
    check_eq("midop_rst_op", op_o, eNop);
    check_eq("midop_rst_game_over", game_over_o, 0);
    check_eq("midop_rst_tile", new_tile_o, eI);
    for (int i = 0; i < 3; i++) begin
      done_v_i  = 1'b1;
      done_ok_i = 1'b1;
      tick(1'b0);
      check_eq("late_done_ignored", op_v_o, 0);
    end
    start_i = 1'b1;
    tick(1'b0);
    next_l = cyc + 1;
    wait_issue();
    check_eq("restart_opcode", op_o, eNew);
    check_eq("restart_cycle", cyc, next_l);
    check_eq("restart_tile", new_tile_o, tile_at(next_l - 1 - rst_edge));

    summary();
    $finish;
  end

endmodule
